regbank_wb_ctrl: RTL

- Write-side initiator for the 8 x 16-bit register bank.
- Accepts writeback requests from two producers (ALU, memory/load unit) over valid/ready handshakes.
- Arbitrates round-robin between them and drives a registered single-port write (wr_en/wr_reg/wr_data) into the bank.
- Keeps a pending-write scoreboard, so the issue stage can reserve destinations and the read stage can detect RAW hazards on its two read addresses.

---
 rtl/regbank_pkg.sv | 16 +
 rtl/rr_arb2.sv | 33 +++
 rtl/regbank_wb_ctrl.sv | 87 ++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// Shared constants and types for the register-bank write-side controller.
// Imported by the arbiter and the writeback controller.
package regbank_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } gnt_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; req[0]=ALU, req[1]=MEM.
// Last-grant state advances only when a grant is actually taken.
module rr_arb2
    import regbank_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    gnt_e last;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == GNT_MEM) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= GNT_MEM;
        end else if (accept) begin
            last <= gnt[0] ? GNT_ALU : GNT_MEM;
        end
    end

endmodule

// File: rtl/regbank_wb_ctrl.sv
// Writeback initiator for the 8x16 register bank: arbitrates ALU/load
// results into a registered write port and tracks pending destinations.
module regbank_wb_ctrl
    import regbank_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_reg,
    output logic              rsv_ready,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_reg,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] r_reg1,
    input  logic [ADDR_W-1:0] r_reg2,
    output logic              hazard1,
    output logic              hazard2,
    output logic [NREG-1:0]   busy_mask
);

    logic [1:0]        gnt;
    logic              accept;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   clr_mask;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({mem_valid, alu_valid}),
        .accept (accept),
        .gnt    (gnt)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];
    assign accept    = gnt[0] | gnt[1];
    assign sel_reg   = gnt[1] ? mem_reg : alu_reg;
    assign sel_data  = gnt[1] ? mem_data : alu_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else if (accept) begin
            wr_en   <= (sel_reg != REG_ZERO);
            wr_reg  <= sel_reg;
            wr_data <= sel_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    assign rsv_ready = rsv_valid && (rsv_reg == REG_ZERO || !busy[rsv_reg]);

    // Set is OR-ed after clear so a same-edge reserve wins over the commit.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (rsv_ready && rsv_reg != REG_ZERO) set_mask = NREG'(1) << rsv_reg;
        if (wr_en) clr_mask = NREG'(1) << wr_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

    assign busy_mask = busy;
    assign hazard1   = busy[r_reg1] && (r_reg1 != REG_ZERO);
    assign hazard2   = busy[r_reg2] && (r_reg2 != REG_ZERO);

endmodule
